// File: rtl/fir_section_mcx_bram_pkg.sv
// Shared definitions for the multi-cycle BRAM FIR section.
// FSM encodings and the minimum accumulator width helper.
package fir_section_mcx_bram_pkg;

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  function automatic int acc_min(
    input int dw,
    input int cw,
    input int lgn
  );
    return dw + cw + 1 + lgn;
  endfunction

endpackage

// File: rtl/fir_section_mcx_bram_if.sv
// Sample, coefficient and result bundle of the FIR section.
// master = upstream/host side, slave = the section itself.
interface fir_section_mcx_bram_if #(
  parameter int DW     = 16,
  parameter int CW     = 18,
  parameter int LGN    = 5,
  parameter int OUT_DW = 16
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DW-1:0]     s_data;
  logic                     sym;
  logic signed [DW-1:0]     f_out;
  logic                     f_valid;
  logic                     coeff_we;
  logic [LGN-1:0]           coeff_addr;
  logic signed [CW-1:0]     coeff_data;
  logic signed [OUT_DW-1:0] result;
  logic                     result_valid;
  logic                     sat;

  modport master (
    output s_valid, s_data, sym,
    output coeff_we, coeff_addr, coeff_data,
    input  s_ready, f_out, f_valid,
    input  result, result_valid, sat
  );

  modport slave (
    input  s_valid, s_data, sym,
    input  coeff_we, coeff_addr, coeff_data,
    output s_ready, f_out, f_valid,
    output result, result_valid, sat
  );
endinterface

// File: rtl/fir_dpram.sv
// Dual-port synchronous RAM: port A write with read-first
// readback, port B read-only. Same-address reads see old data.
module fir_dpram #(
  parameter int W  = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          we_a,
  input  logic          re_a,
  input  logic [AW-1:0] addr_a,
  input  logic [W-1:0]  din_a,
  output logic [W-1:0]  dout_a,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  output logic [W-1:0]  dout_b
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (ce && we_a) mem[addr_a] <= din_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a <= '0;
      dout_b <= '0;
    end else if (ce) begin
      if (re_a) dout_a <= mem[addr_a];
      if (re_b) dout_b <= mem[addr_b];
    end
  end
endmodule

// File: rtl/fir_section_mcx_bram.sv
// Single-multiplier FIR section, symmetric or asymmetric per sample,
// with rounding, saturation and a cascade tap of the evicted sample.
module fir_section_mcx_bram
  import fir_section_mcx_bram_pkg::*;
#(
  parameter int DW     = 16,
  parameter int CW     = 18,
  parameter int NUMW   = 17,
  parameter int LGN    = 5,
  parameter int ACCW   = 48,
  parameter int OUT_DW = 16
) (
  input  logic clk_sample,
  input  logic reset,
  input  logic ce,
  fir_section_mcx_bram_if.slave bus
);
  localparam int PW = DW + CW + 1;
  localparam logic signed [ACCW-1:0] RND =
    {{(ACCW-1){1'b0}}, 1'b1} << (NUMW - 1);
  localparam logic signed [ACCW-1:0] SAT_HI =
    {{(ACCW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO =
    {{(ACCW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

  if (ACCW < acc_min(DW, CW, LGN)) begin : g_bad_accw
    $error("ACCW too narrow for DW+CW+1+LGN");
  end

  logic [2:0]               state;
  logic [LGN-1:0]           cnt;
  logic [LGN-1:0]           wr_ptr;
  logic                     sym_q;
  logic                     v1;
  logic                     v2;
  logic signed [PW-1:0]     prod;
  logic signed [ACCW-1:0]   acc;
  logic signed [OUT_DW-1:0] result_q;
  logic                     rv_q;
  logic                     sat_q;
  logic                     fv_q;

  logic                     accept;
  logic                     clearing;
  logic [LGN-1:0]           k_last;
  logic                     dl_we;
  logic [LGN-1:0]           dl_addr;
  logic [DW-1:0]            dl_din;
  logic [DW-1:0]            f_word;
  logic [DW-1:0]            x0_w;
  logic [DW-1:0]            x1_w;
  logic [DW-1:0]            x1_unused;
  logic [CW-1:0]            h_w;
  logic [CW-1:0]            h_unused;
  logic signed [DW:0]       pre;
  logic signed [CW-1:0]     h;
  logic signed [PW-1:0]     prod_c;
  logic signed [ACCW-1:0]   rnd_q;
  logic signed [OUT_DW-1:0] res_c;
  logic                     clip_c;
  logic                     unused_ok;

  assign clearing = (state == ST_CLEAR);
  assign bus.s_ready = (state == ST_IDLE);
  assign accept = bus.s_valid & bus.s_ready & ce;
  assign k_last = sym_q ? {1'b0, {(LGN-1){1'b1}}}
                        : {LGN{1'b1}};

  assign dl_we   = clearing | accept;
  assign dl_addr = clearing ? cnt : wr_ptr;
  assign dl_din  = clearing ? '0 : bus.s_data;

  // Two identical delay copies give the pair of taps per cycle.
  fir_dpram #(.W(DW), .AW(LGN)) u_dl0 (
    .clk(clk_sample), .rst(reset), .ce(ce),
    .we_a(dl_we), .re_a(accept), .addr_a(dl_addr),
    .din_a(dl_din), .dout_a(f_word),
    .re_b(1'b1), .addr_b(wr_ptr - cnt), .dout_b(x0_w)
  );

  fir_dpram #(.W(DW), .AW(LGN)) u_dl1 (
    .clk(clk_sample), .rst(reset), .ce(ce),
    .we_a(dl_we), .re_a(1'b0), .addr_a(dl_addr),
    .din_a(dl_din), .dout_a(x1_unused),
    .re_b(1'b1), .addr_b(wr_ptr + cnt + LGN'(1)),
    .dout_b(x1_w)
  );

  fir_dpram #(.W(CW), .AW(LGN)) u_coef (
    .clk(clk_sample), .rst(reset), .ce(ce),
    .we_a(bus.coeff_we), .re_a(1'b0),
    .addr_a(bus.coeff_addr), .din_a(bus.coeff_data),
    .dout_a(h_unused),
    .re_b(1'b1), .addr_b(cnt), .dout_b(h_w)
  );

  assign unused_ok = ^{x1_unused, h_unused};

  assign h   = h_w;
  assign pre = sym_q ? ({x0_w[DW-1], x0_w} + {x1_w[DW-1], x1_w})
                     : {x0_w[DW-1], x0_w};
  assign prod_c = PW'(pre) * PW'(h);
  assign rnd_q  = (acc + RND) >>> NUMW;

  always_comb begin
    res_c  = rnd_q[OUT_DW-1:0];
    clip_c = 1'b0;
    unique case (1'b1)
      (rnd_q > SAT_HI): begin
        res_c  = SAT_HI[OUT_DW-1:0];
        clip_c = 1'b1;
      end
      (rnd_q < SAT_LO): begin
        res_c  = SAT_LO[OUT_DW-1:0];
        clip_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sample) begin
    if (reset) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      wr_ptr   <= '0;
      sym_q    <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      sat_q    <= 1'b0;
      fv_q     <= 1'b0;
    end else if (ce) begin
      fv_q <= accept;
      rv_q <= 1'b0;
      sat_q <= 1'b0;
      v1   <= (state == ST_MAC);
      v2   <= v1;
      prod <= prod_c;
      if (v2) acc <= acc + ACCW'(prod);
      unique case (state)
        ST_CLEAR: begin
          cnt <= cnt + LGN'(1);
          if (cnt == {LGN{1'b1}}) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            sym_q <= bus.sym;
            acc   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (cnt == k_last) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + LGN'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt[0]) begin
            cnt   <= '0;
            state <= ST_OUT;
          end else begin
            cnt <= cnt + LGN'(1);
          end
        end
        ST_OUT: begin
          state    <= ST_IDLE;
          wr_ptr   <= wr_ptr + LGN'(1);
          result_q <= res_c;
          sat_q    <= clip_c;
          rv_q     <= 1'b1;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.f_out        = f_word;
  assign bus.f_valid      = fv_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.sat          = sat_q;
endmodule

// File: tb/tb_fir_section_mcx_bram.sv
// Self-checking bench for fir_section_mcx_bram against a
// history-queue reference model of the FIR equations.
module tb_fir_section_mcx_bram;
  localparam int D    = 32;
  localparam int NUMW = 17;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  bit   ce_rand = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  int hist[$];
  int h_m[D];

  fir_section_mcx_bram_if #(
    .DW(16), .CW(18), .LGN(5), .OUT_DW(16)
  ) bus ();

  fir_section_mcx_bram #(
    .DW(16), .CW(18), .NUMW(NUMW), .LGN(5),
    .ACCW(48), .OUT_DW(16)
  ) dut (
    .clk_sample(clk),
    .reset(reset),
    .ce(ce),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back(0);
  endfunction

  function automatic void model_step(
    input int x, input bit m,
    output int evict, output int y, output bit s
  );
    longint acc = 0;
    longint r;
    evict = hist[D-1];
    void'(hist.pop_back());
    hist.push_front(x);
    if (m) begin
      for (int k = 0; k < D / 2; k++)
        acc += longint'(h_m[k]) * longint'(hist[k] + hist[D-1-k]);
    end else begin
      for (int k = 0; k < D; k++)
        acc += longint'(h_m[k]) * longint'(hist[k]);
    end
    r = (acc + (longint'(1) << (NUMW - 1))) >>> NUMW;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    if (r < -32768) begin r = -32768; s = 1'b1; end
    y = int'(r);
  endfunction

  task automatic load_coeffs();
    for (int k = 0; k < D; k++) begin
      bus.coeff_we   = 1'b1;
      bus.coeff_addr = 5'(k);
      bus.coeff_data = 18'(h_m[k]);
      @(negedge clk);
    end
    bus.coeff_we = 1'b0;
  endtask

  task automatic drive(
    input int x, input bit m, input bit hold, input bit chk_lat,
    output int got, output bit gsat
  );
    int n;
    int ev;
    int y;
    bit s;
    got = 0;
    gsat = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'(x);
    bus.sym     = m;
    n = 0;
    while (!(bus.s_ready && ce)) begin
      @(negedge clk);
      n++;
      if (n > BUDGET) begin
        total++; bad++;
        $display("FAIL accept_timeout: no accept in %0d cycles", n);
        bus.s_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) bus.s_valid = 1'b0;
    model_step(x, m, ev, y, s);
    total++;
    if (bus.f_valid !== 1'b1) begin
      bad++;
      $display("FAIL f_valid: got %b want 1", bus.f_valid);
    end
    total++;
    if (bus.f_out !== 16'(ev)) begin
      bad++;
      $display("FAIL f_out: got %0d want %0d", bus.f_out, ev);
    end
    n = 0;
    while (!bus.result_valid) begin
      @(negedge clk);
      n++;
      if (n > BUDGET) begin
        total++; bad++;
        $display("FAIL result_timeout: no result_valid");
        return;
      end
    end
    if (chk_lat) begin
      total++;
      if (n !== (m ? D / 2 : D) + 3) begin
        bad++;
        $display("FAIL latency: got %0d want %0d", n,
                 (m ? D / 2 : D) + 3);
      end
    end
    total++;
    if (bus.result !== 16'(y)) begin
      bad++;
      $display("FAIL result: got %0d want %0d", bus.result, y);
    end
    total++;
    if (bus.sat !== s) begin
      bad++;
      $display("FAIL sat: got %b want %b", bus.sat, s);
    end
    got  = int'(bus.result);
    gsat = bus.sat;
  endtask

  task automatic apply_reset();
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!bus.s_ready) begin
      @(negedge clk);
      n++;
      if (n > BUDGET) begin
        total++; bad++;
        $display("FAIL clear_timeout: s_ready never rose");
        break;
      end
    end
    model_reset();
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.coeff_we = 1'b0;
    bus.s_data = '0;
    bus.sym = 1'b0;
    bus.coeff_addr = '0;
    bus.coeff_data = '0;
    repeat (3) @(negedge clk);
    total += 6;
    if (bus.s_ready !== 1'b0) begin bad++;
      $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    if (bus.f_out !== 16'sd0) begin bad++;
      $display("FAIL rst_f_out: got %0d want 0", bus.f_out); end
    if (bus.f_valid !== 1'b0) begin bad++;
      $display("FAIL rst_f_valid: got %b want 0", bus.f_valid); end
    if (bus.result !== 16'sd0) begin bad++;
      $display("FAIL rst_result: got %0d want 0", bus.result); end
    if (bus.result_valid !== 1'b0) begin bad++;
      $display("FAIL rst_rv: got %b want 0", bus.result_valid); end
    if (bus.sat !== 1'b0) begin bad++;
      $display("FAIL rst_sat: got %b want 0", bus.sat); end
    reset = 1'b0;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== D) begin
      bad++;
      $display("FAIL clear_len: got %0d want %0d", n, D);
    end
    model_reset();
  endtask

  task automatic test_impulse(input bit load);
    int got;
    bit gs;
    int want;
    if (load) begin
      for (int k = 0; k < D; k++) h_m[k] = k * (1 << NUMW) / 64;
      load_coeffs();
    end
    for (int j = 0; j <= D; j++) begin
      drive((j == 0) ? 1000 : 0, 1'b0, 1'b0, 1'b1, got, gs);
      want = (j < D) ? (1000 * j + 32) / 64 : 0;
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL impulse[%0d]: got %0d want %0d", j, got, want);
      end
    end
  endtask

  task automatic test_symmetric();
    int got;
    bit gs;
    for (int k = 0; k < D; k++)
      h_m[k] = (k < D / 2) ? (1 << NUMW) - 1 : 0;
    load_coeffs();
    for (int i = 0; i < 40; i++)
      drive(100, 1'b1, 1'b0, 1'b1, got, gs);
    total++;
    if (got !== 3200 || gs !== 1'b0) begin
      bad++;
      $display("FAIL sym_steady: got %0d/%b want 3200/0", got, gs);
    end
  endtask

  task automatic test_saturation();
    int got;
    bit gs;
    for (int k = 0; k < D; k++) h_m[k] = (1 << NUMW) - 1;
    load_coeffs();
    for (int i = 0; i <= D; i++)
      drive(32767, 1'b0, 1'b0, 1'b1, got, gs);
    total++;
    if (got !== 32767 || gs !== 1'b1) begin
      bad++;
      $display("FAIL sat_pos: got %0d/%b want 32767/1", got, gs);
    end
    for (int i = 0; i <= D; i++)
      drive(-32768, 1'b0, 1'b0, 1'b1, got, gs);
    total++;
    if (got !== -32768 || gs !== 1'b1) begin
      bad++;
      $display("FAIL sat_neg: got %0d/%b want -32768/1", got, gs);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    bit gs;
    int last;
    bit prev_m;
    bit m;
    for (int k = 0; k < D; k++)
      h_m[k] = int'($signed(18'($urandom))) >>> 3;
    load_coeffs();
    last = 0;
    prev_m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      drive(int'($signed(16'($urandom))), m, 1'b1, 1'b1, got, gs);
      if (i > 0) begin
        total++;
        if (acc_cyc - last !== (prev_m ? D / 2 : D) + 4) begin
          bad++;
          $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i,
                   acc_cyc - last, (prev_m ? D / 2 : D) + 4);
        end
      end
      last = acc_cyc;
      prev_m = m;
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mac();
    int n;
    bit rv_seen;
    for (int k = 0; k < D; k++) h_m[k] = k * (1 << NUMW) / 64;
    load_coeffs();
    bus.s_valid = 1'b1;
    bus.s_data = 16'sd1000;
    bus.sym = 1'b0;
    n = 0;
    while (!bus.s_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    rv_seen = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    if (bus.result_valid) rv_seen = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.result_valid) rv_seen = 1'b1;
    end
    total++;
    if (n !== D) begin
      bad++;
      $display("FAIL abort_clear_len: got %0d want %0d", n, D);
    end
    total++;
    if (rv_seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_rv: got %b want 0", rv_seen);
    end
    model_reset();
    test_impulse(1'b0);
  endtask

  task automatic test_ce_gating();
    int xs[3*D];
    bit ms[3*D];
    int ref_y[3*D];
    bit ref_s[3*D];
    int got;
    bit gs;
    for (int k = 0; k < D; k++)
      h_m[k] = int'($signed(18'($urandom))) >>> 3;
    load_coeffs();
    for (int i = 0; i < 3 * D; i++) begin
      xs[i] = int'($signed(16'($urandom)));
      ms[i] = 1'($urandom_range(0, 1));
    end
    apply_reset();
    for (int i = 0; i < 3 * D; i++)
      drive(xs[i], ms[i], 1'b0, 1'b1, ref_y[i], ref_s[i]);
    ce_rand = 1'b1;
    apply_reset();
    for (int i = 0; i < 3 * D; i++) begin
      drive(xs[i], ms[i], 1'b0, 1'b0, got, gs);
      total++;
      if (got !== ref_y[i] || gs !== ref_s[i]) begin
        bad++;
        $display("FAIL ce_replay[%0d]: got %0d/%b want %0d/%b",
                 i, got, gs, ref_y[i], ref_s[i]);
      end
    end
    ce_rand = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.coeff_we = 1'b0;
    test_reset();
    test_impulse(1'b1);
    test_symmetric();
    test_saturation();
    test_back_to_back();
    test_reset_mid_mac();
    test_ce_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
